mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one variable-latency backing memory port between the instruction-fetch requester (IF stage) and the data requester (MEM stage) of the 5-stage MIPS pipeline. It holds at most one transaction outstanding and registers returned data. It produces per-stage stall requests for the hazard unit and a sticky error flag from a no-acknowledge watchdog. It sits between the IF/MEM stages and the unified memory interface.

## Interface
- TIMEOUT_CYCLES, 64, cycles a granted transaction may wait for MemAck_IN before abort (≥2)
- ERROR_DATA, 32'h0000_0000, data returned on a timed-out read
- CLOCK  in  1  sole clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- IReq_IN  in  1  instruction fetch request, held until IDone_OUT
- IAddr_IN  in  32  fetch address
- IData_OUT  out  32  fetched instruction, valid while IDone_OUT=1
- IDone_OUT  out  1  one-cycle fetch completion pulse
- DRead_IN / DWrite_IN  in  1 each  data read / write request, held until DDone_OUT
- DAddr_IN  in  32  data address
- DWriteData_IN  in  32  store data
- DSize_IN  in  2  bytes: 1,2,3; 0 = 4
- DData_OUT  out  32  load data, valid while DDone_OUT=1
- DDone_OUT  out  1  one-cycle data completion pulse
- MemReq_OUT, MemWe_OUT  out  1 each  backing-port request / write enable
- MemAddr_OUT, MemWData_OUT  out  32 each  backing-port address / write data
- MemSize_OUT  out  2  backing-port size, same encoding as DSize_IN
- MemAck_IN  in  1  backing-port acknowledge; MemRData_IN valid in the same cycle
- MemRData_IN  in  32  backing-port read data
- StallIF_OUT, StallMEM_OUT  out  1 each  stall requests to the hazard unit
- Error_OUT  out  1  sticky timeout flag

## Operation
- States: IDLE, IBUSY, DBUSY, IDONE, DDONE.
- IDLE → DBUSY if a D request is pending and I is not. IDLE → IBUSY if I is pending and D is not.
- Both pending in IDLE: grant D unless the last grant was D, then grant I. This alternates under contention. The last-grant register resets to I.
- On grant, register MemAddr/MemWData/MemSize/MemWe from the winning requester. Fields stay stable while busy. I grants: MemWe=0, MemSize=0.
- DRead_IN and DWrite_IN both high: treat as a write.
- BUSY with MemAck_IN=1: capture MemRData_IN (D reads only) and go to the matching DONE state. DData_OUT is unchanged on writes.
- DONE asserts the matching Done pulse for exactly one cycle, then returns to IDLE. Requests are sampled again only in IDLE. A request still high during DONE is treated as a new request.
- Watchdog: counts from 0 on entry to BUSY. If it reaches TIMEOUT_CYCLES-1 with no ack, go to DONE anyway: data = ERROR_DATA (reads), Error_OUT←1. Error_OUT clears only on reset.
- StallIF_OUT = IReq_IN & ~IDone_OUT. StallMEM_OUT = (DRead_IN|DWrite_IN) & ~DDone_OUT. Both are combinational.
- MemAck_IN outside BUSY is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0, last grant = I. The clear is asynchronous and takes effect immediately, including mid-transaction (MemReq_OUT drops without waiting for ack).
- Request seen in IDLE at cycle 0 → MemReq_OUT=1 from cycle 1.
- Earliest ack is cycle 1 → Done at cycle 2, so minimum latency is 2 cycles. Ack at cycle k → Done at cycle k+1.
- MemReq_OUT deasserts in the cycle after the ack/timeout cycle (the DONE cycle).
- Back-to-back: the next grant's MemReq_OUT rises at the earliest 2 cycles after the previous Done.
- Timeout: granted at cycle 0 with no ack → Done at cycle TIMEOUT_CYCLES+1.

## Structure
- Shared package mips_mem_pkg holds the state enum, the grant enum (GRANT_I, GRANT_D) and the DataSize encoding constants (SIZE_WORD=0, SIZE_BYTE=1, SIZE_HALF=2).
- One sub-module, mem_wait_timer: a $clog2(TIMEOUT_CYCLES)-bit counter with clear/enable inputs and an expired output.

## Test plan
- Fetch only: IReq=1, IAddr=0x00400000, ack at cycle 3 with 0x8C220004 → MemAddr=0x00400000, MemWe=0, IDone=1 at cycle 4 only, IData=0x8C220004.
- Contention: IReq (0x00400000) and DRead (0x10010000) rise together → D served first, then I. In a second contention, I is served first.
- Byte store: DWrite, DAddr=0x10010003, DSize=1, data 0x000000AB → MemWe=1, MemSize=1, MemWData=0x000000AB, DDone pulses once, DData_OUT unchanged.
- Timeout: TIMEOUT_CYCLES=8, DRead with no ack → MemReq high 8 cycles, DDone at cycle 9 with DData=0, Error_OUT=1 and held.
- Reset mid-operation: RESET low during DBUSY → all outputs 0 immediately. After release, a new IReq completes normally and the first contention grants D.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// ----------------------------------------------------------------------------
// mips_mem_pkg
// Types and constants shared by the memory-port arbiter and its wait timer.
//   arbState_e : arbiter FSM states
//   grant_e    : which requester owns (or last owned) the backing port
//   SIZE_*     : DataSize encoding used on DSize_IN / MemSize_OUT
// ----------------------------------------------------------------------------
package mips_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        IBUSY,
        DBUSY,
        IDONE,
        DDONE
    } arbState_e;

    typedef enum logic {
        GRANT_I,
        GRANT_D
    } grant_e;

    localparam logic [1:0] SIZE_WORD = 2'd0;
    localparam logic [1:0] SIZE_BYTE = 2'd1;
    localparam logic [1:0] SIZE_HALF = 2'd2;

    // A transaction is on the backing port in either BUSY state.
    function automatic logic isBusy(input arbState_e s);
        return (s == IBUSY) || (s == DBUSY);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// ----------------------------------------------------------------------------
// mem_wait_timer
// Counts cycles spent waiting for a backing-port acknowledge.
//   CLOCK, RESET : clock, asynchronous active-low reset
//   clear        : force the count to 0 (takes priority over enable)
//   enable       : advance the count by one per cycle
//   expired      : count has reached TIMEOUT_CYCLES-1
// The count saturates at TIMEOUT_CYCLES-1 so expired stays high until cleared.
// ----------------------------------------------------------------------------
module mem_wait_timer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    assign expired = (count == LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one variable-latency memory port between the IF-stage fetcher and
// the MEM-stage data requester, one transaction outstanding at a time.
//   IReq_IN/IAddr_IN              : fetch request, held until IDone_OUT
//   IData_OUT/IDone_OUT           : fetched word, one-cycle completion pulse
//   DRead_IN/DWrite_IN/DAddr_IN/
//   DWriteData_IN/DSize_IN        : data request, held until DDone_OUT
//   DData_OUT/DDone_OUT           : load data, one-cycle completion pulse
//   MemReq_OUT/MemWe_OUT/MemAddr_OUT/
//   MemWData_OUT/MemSize_OUT      : backing-port request fields (registered)
//   MemAck_IN/MemRData_IN         : backing-port acknowledge and read data
//   StallIF_OUT/StallMEM_OUT      : stall requests for the hazard unit
//   Error_OUT                     : sticky no-acknowledge timeout flag
// Under contention the D side wins unless it won last time, so the two
// requesters alternate.
// ----------------------------------------------------------------------------
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] ERROR_DATA     = 32'h0000_0000
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        IReq_IN,
    input  logic [31:0] IAddr_IN,
    output logic [31:0] IData_OUT,
    output logic        IDone_OUT,
    input  logic        DRead_IN,
    input  logic        DWrite_IN,
    input  logic [31:0] DAddr_IN,
    input  logic [31:0] DWriteData_IN,
    input  logic [1:0]  DSize_IN,
    output logic [31:0] DData_OUT,
    output logic        DDone_OUT,
    output logic        MemReq_OUT,
    output logic        MemWe_OUT,
    output logic [31:0] MemAddr_OUT,
    output logic [31:0] MemWData_OUT,
    output logic [1:0]  MemSize_OUT,
    input  logic        MemAck_IN,
    input  logic [31:0] MemRData_IN,
    output logic        StallIF_OUT,
    output logic        StallMEM_OUT,
    output logic        Error_OUT
);

    arbState_e state, nextState;
    grant_e    lastGrant;
    logic      dPending;
    logic      expired;
    logic      finish;

    assign dPending = DRead_IN | DWrite_IN;
    // A busy transaction ends on acknowledge or when the watchdog runs out.
    assign finish   = MemAck_IN | expired;

    mem_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) uTimer (
        .CLOCK  (CLOCK),
        .RESET  (RESET),
        .clear  (!isBusy(state)),
        .enable (isBusy(state)),
        .expired(expired)
    );

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement leaves a signal unassigned (no latches).
    always_comb begin
        nextState  = state;
        MemReq_OUT = isBusy(state);
        IDone_OUT  = (state == IDONE);
        DDone_OUT  = (state == DDONE);
        unique case (state)
            IDLE: begin
                if (dPending && IReq_IN) begin
                    nextState = (lastGrant == GRANT_D) ? IBUSY : DBUSY;
                end else if (dPending) begin
                    nextState = DBUSY;
                end else if (IReq_IN) begin
                    nextState = IBUSY;
                end
            end
            IBUSY:   if (finish) nextState = IDONE;
            DBUSY:   if (finish) nextState = DDONE;
            IDONE,
            DDONE:   nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    assign StallIF_OUT  = IReq_IN & ~IDone_OUT;
    assign StallMEM_OUT = dPending & ~DDone_OUT;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state        <= IDLE;
            lastGrant    <= GRANT_I;
            MemAddr_OUT  <= '0;
            MemWData_OUT <= '0;
            MemSize_OUT  <= SIZE_WORD;
            MemWe_OUT    <= 1'b0;
            IData_OUT    <= '0;
            DData_OUT    <= '0;
            Error_OUT    <= 1'b0;
        end else begin
            state <= nextState;

            // Latch the winner's request fields once, at grant time.
            if (state == IDLE && nextState == IBUSY) begin
                MemAddr_OUT  <= IAddr_IN;
                MemWData_OUT <= '0;
                MemSize_OUT  <= SIZE_WORD;
                MemWe_OUT    <= 1'b0;
                lastGrant    <= GRANT_I;
            end else if (state == IDLE && nextState == DBUSY) begin
                MemAddr_OUT  <= DAddr_IN;
                MemWData_OUT <= DWriteData_IN;
                MemSize_OUT  <= DSize_IN;
                MemWe_OUT    <= DWrite_IN;  // read+write together is a write
                lastGrant    <= GRANT_D;
            end

            // Ack wins over a same-cycle watchdog expiry.
            if (state == IBUSY) begin
                if (MemAck_IN) begin
                    IData_OUT <= MemRData_IN;
                end else if (expired) begin
                    IData_OUT <= ERROR_DATA;
                    Error_OUT <= 1'b1;
                end
            end

            // Stores leave DData_OUT holding the last load result.
            if (state == DBUSY) begin
                if (MemAck_IN) begin
                    if (!MemWe_OUT) DData_OUT <= MemRData_IN;
                end else if (expired) begin
                    if (!MemWe_OUT) DData_OUT <= ERROR_DATA;
                    Error_OUT <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    import mips_mem_pkg::*;

    localparam int          TO   = 8;
    localparam logic [31:0] ERRD = 32'h0000_0000;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        IReq_IN = 1'b0;
    logic [31:0] IAddr_IN = '0;
    logic [31:0] IData_OUT;
    logic        IDone_OUT;
    logic        DRead_IN = 1'b0;
    logic        DWrite_IN = 1'b0;
    logic [31:0] DAddr_IN = '0;
    logic [31:0] DWriteData_IN = '0;
    logic [1:0]  DSize_IN = '0;
    logic [31:0] DData_OUT;
    logic        DDone_OUT;
    logic        MemReq_OUT;
    logic        MemWe_OUT;
    logic [31:0] MemAddr_OUT;
    logic [31:0] MemWData_OUT;
    logic [1:0]  MemSize_OUT;
    logic        MemAck_IN = 1'b0;
    logic [31:0] MemRData_IN = '0;
    logic        StallIF_OUT;
    logic        StallMEM_OUT;
    logic        Error_OUT;

    mem_port_arbiter #(.TIMEOUT_CYCLES(TO), .ERROR_DATA(ERRD)) dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .IReq_IN(IReq_IN), .IAddr_IN(IAddr_IN), .IData_OUT(IData_OUT), .IDone_OUT(IDone_OUT),
        .DRead_IN(DRead_IN), .DWrite_IN(DWrite_IN), .DAddr_IN(DAddr_IN),
        .DWriteData_IN(DWriteData_IN), .DSize_IN(DSize_IN),
        .DData_OUT(DData_OUT), .DDone_OUT(DDone_OUT),
        .MemReq_OUT(MemReq_OUT), .MemWe_OUT(MemWe_OUT), .MemAddr_OUT(MemAddr_OUT),
        .MemWData_OUT(MemWData_OUT), .MemSize_OUT(MemSize_OUT),
        .MemAck_IN(MemAck_IN), .MemRData_IN(MemRData_IN),
        .StallIF_OUT(StallIF_OUT), .StallMEM_OUT(StallMEM_OUT), .Error_OUT(Error_OUT)
    );

    always #5 CLOCK = ~CLOCK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- environment rules (memory behaviour by address) -------
    function automatic bit isTimeoutAddr(input logic [31:0] a);
        return a[11:8] == 4'hF;
    endfunction

    function automatic int latOf(input logic [31:0] a);
        return 1 + ((int'(a[4:2]) + 2) % 4);
    endfunction

    function automatic logic [31:0] initContent(input logic [31:0] a);
        return a ^ 32'hC3C3_3C3C;
    endfunction

    // ---------------- reference model ---------------------------------------
    typedef struct {
        logic [31:0] data;
        bit          timeout;
        int          lat;
    } exp_t;

    exp_t        iQ[$];
    exp_t        dQ[$];
    logic [31:0] refMem [logic [31:0]];
    logic [31:0] lastDData = '0;

    function automatic logic [31:0] refRead(input logic [31:0] a);
        if (refMem.exists(a)) return refMem[a];
        return initContent(a);
    endfunction

    // ---------------- backing memory responder ------------------------------
    logic [31:0] respMem [logic [31:0]];
    int          respCnt = 0;

    always @(negedge CLOCK) begin
        MemAck_IN = 1'b0;
        if (!RESET) begin
            respCnt = 0;
        end else if (MemReq_OUT) begin
            respCnt++;
            if (!isTimeoutAddr(MemAddr_OUT) && respCnt == latOf(MemAddr_OUT)) begin
                MemAck_IN = 1'b1;
                if (MemWe_OUT) begin
                    respMem[MemAddr_OUT] = MemWData_OUT;
                    MemRData_IN = $urandom;
                end else begin
                    MemRData_IN = respMem.exists(MemAddr_OUT) ? respMem[MemAddr_OUT]
                                                              : initContent(MemAddr_OUT);
                end
            end
        end else begin
            respCnt = 0;
            if ($urandom_range(0, 3) == 0) begin
                MemAck_IN   = 1'b1;           // stray ack outside a transaction
                MemRData_IN = $urandom;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------------------------
    bit          monEn = 1'b0;
    grant_e      lastGrantM = GRANT_I;
    bit          curIsD = 1'b0;
    bit          errSeen = 1'b0;
    int          busyCycles = 0;
    logic        prevMemReq = 1'b0, prevIPend = 1'b0, prevDPend = 1'b0;
    logic        prevIDone = 1'b0, prevDDone = 1'b0, prevDWrite = 1'b0;
    logic [31:0] prevIAddr = '0, prevDAddr = '0, prevDWData = '0;
    logic [1:0]  prevDSize = '0;

    always @(negedge CLOCK) begin
        exp_t e;
        bit   winD;
        if (monEn) begin
            check("stall_if", {31'b0, StallIF_OUT}, {31'b0, IReq_IN & ~IDone_OUT});
            check("stall_mem", {31'b0, StallMEM_OUT},
                  {31'b0, (DRead_IN | DWrite_IN) & ~DDone_OUT});

            if (MemReq_OUT && !prevMemReq) begin
                check("grant_pending", {31'b0, prevIPend | prevDPend}, 32'd1);
                winD = prevDPend && (!prevIPend || lastGrantM == GRANT_I);
                if (winD) begin
                    check("d_addr", MemAddr_OUT, prevDAddr);
                    check("d_we", {31'b0, MemWe_OUT}, {31'b0, prevDWrite});
                    check("d_size", {30'b0, MemSize_OUT}, {30'b0, prevDSize});
                    check("d_wdata", MemWData_OUT, prevDWData);
                    lastGrantM = GRANT_D;
                end else begin
                    check("i_addr", MemAddr_OUT, prevIAddr);
                    check("i_we", {31'b0, MemWe_OUT}, 32'd0);
                    check("i_size", {30'b0, MemSize_OUT}, {30'b0, SIZE_WORD});
                    lastGrantM = GRANT_I;
                end
                curIsD     = winD;
                busyCycles = 0;
            end
            if (MemReq_OUT) busyCycles++;

            if (IDone_OUT) begin
                check("idone_side", {31'b0, curIsD}, 32'd0);
                check("idone_pulse", {31'b0, prevIDone}, 32'd0);
                check("idone_expected", 32'(iQ.size() > 0), 32'd1);
                if (iQ.size() > 0) begin
                    e = iQ.pop_front();
                    errSeen |= e.timeout;
                    check("idata", IData_OUT, e.data);
                    check("i_latency", 32'(busyCycles), 32'(e.timeout ? TO : e.lat));
                    check("error_flag", {31'b0, Error_OUT}, {31'b0, errSeen});
                end
            end
            if (DDone_OUT) begin
                check("ddone_side", {31'b0, curIsD}, 32'd1);
                check("ddone_pulse", {31'b0, prevDDone}, 32'd0);
                check("ddone_expected", 32'(dQ.size() > 0), 32'd1);
                if (dQ.size() > 0) begin
                    e = dQ.pop_front();
                    errSeen |= e.timeout;
                    check("ddata", DData_OUT, e.data);
                    check("d_latency", 32'(busyCycles), 32'(e.timeout ? TO : e.lat));
                    check("error_flag", {31'b0, Error_OUT}, {31'b0, errSeen});
                end
            end
        end
        prevMemReq = MemReq_OUT;
        prevIPend  = IReq_IN;
        prevDPend  = DRead_IN | DWrite_IN;
        prevIDone  = IDone_OUT;
        prevDDone  = DDone_OUT;
        prevIAddr  = IAddr_IN;
        prevDAddr  = DAddr_IN;
        prevDWrite = DWrite_IN;
        prevDSize  = DSize_IN;
        prevDWData = DWriteData_IN;
    end

    // ---------------- stimulus tasks ----------------------------------------
    task automatic issueI(input logic [31:0] a);
        exp_t e;
        int   n = 0;
        @(posedge CLOCK); #1;
        IReq_IN  = 1'b1;
        IAddr_IN = a;
        e.timeout = isTimeoutAddr(a);
        e.lat     = latOf(a);
        e.data    = e.timeout ? ERRD : refRead(a);
        iQ.push_back(e);
        do begin
            @(negedge CLOCK);
            n++;
        end while (!IDone_OUT && n < 100);
        check("idone_seen", {31'b0, IDone_OUT}, 32'd1);
        @(posedge CLOCK); #1;
        IReq_IN = 1'b0;
    endtask

    task automatic issueD(input logic [31:0] a, input bit rd, input bit wr,
                          input logic [1:0] sz, input logic [31:0] wd);
        exp_t e;
        int   n = 0;
        @(posedge CLOCK); #1;
        DRead_IN      = rd;
        DWrite_IN     = wr;
        DAddr_IN      = a;
        DSize_IN      = sz;
        DWriteData_IN = wd;
        e.timeout = isTimeoutAddr(a);
        e.lat     = latOf(a);
        if (wr) begin
            if (!e.timeout) refMem[a] = wd;
        end else begin
            lastDData = e.timeout ? ERRD : refRead(a);
        end
        e.data = lastDData;
        dQ.push_back(e);
        do begin
            @(negedge CLOCK);
            n++;
        end while (!DDone_OUT && n < 100);
        check("ddone_seen", {31'b0, DDone_OUT}, 32'd1);
        @(posedge CLOCK); #1;
        DRead_IN  = 1'b0;
        DWrite_IN = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_memreq"}, {31'b0, MemReq_OUT}, 32'd0);
        check({tag, "_memwe"}, {31'b0, MemWe_OUT}, 32'd0);
        check({tag, "_memaddr"}, MemAddr_OUT, 32'd0);
        check({tag, "_memwdata"}, MemWData_OUT, 32'd0);
        check({tag, "_memsize"}, {30'b0, MemSize_OUT}, 32'd0);
        check({tag, "_idata"}, IData_OUT, 32'd0);
        check({tag, "_ddata"}, DData_OUT, 32'd0);
        check({tag, "_idone"}, {31'b0, IDone_OUT}, 32'd0);
        check({tag, "_ddone"}, {31'b0, DDone_OUT}, 32'd0);
        check({tag, "_error"}, {31'b0, Error_OUT}, 32'd0);
        check({tag, "_stallif"}, {31'b0, StallIF_OUT}, 32'd0);
        check({tag, "_stallmem"}, {31'b0, StallMEM_OUT}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    // ---------------- main sequence -----------------------------------------
    initial begin
        int n;
        refMem[32'h0040_0000]  = 32'h8C22_0004;
        respMem[32'h0040_0000] = 32'h8C22_0004;

        RESET = 1'b1;
        #3 RESET = 1'b0;
        repeat (2) @(negedge CLOCK);
        checkAllZero("reset");
        RESET = 1'b1;
        @(posedge CLOCK); #2 monEn = 1'b1;

        // Directed: fetch, byte store, read-back, watchdog timeout.
        issueI(32'h0040_0000);
        issueD(32'h1001_0003, 1'b0, 1'b1, SIZE_BYTE, 32'h0000_00AB);
        issueD(32'h1001_0003, 1'b1, 1'b0, SIZE_BYTE, 32'h0);
        issueD(32'h1001_0F00, 1'b1, 1'b0, SIZE_WORD, 32'h0);

        // Directed contention: last grant was D, so I goes first.
        fork
            issueI(32'h0040_0010);
            issueD(32'h1001_0008, 1'b1, 1'b0, SIZE_HALF, 32'h0);
        join

        // Randomized concurrent traffic from both stages.
        fork
            for (int i = 0; i < 30; i++) begin
                repeat ($urandom_range(0, 3)) @(posedge CLOCK);
                issueI(32'h0040_0000 + (32'($urandom_range(0, 255)) << 2));
            end
            for (int j = 0; j < 30; j++) begin
                int          op;
                logic [31:0] a;
                repeat ($urandom_range(0, 3)) @(posedge CLOCK);
                op = $urandom_range(0, 2);
                a  = 32'h1001_0000 + (($urandom_range(0, 9) == 0) ? 32'h0F00 : 32'h0)
                     + (32'($urandom_range(0, 7)) << 2);
                issueD(a, op != 1, op != 0, 2'($urandom_range(0, 3)), $urandom);
            end
        join

        // Reset in the middle of a data transaction.
        @(posedge CLOCK); #2 monEn = 1'b0;
        @(posedge CLOCK); #1;
        DRead_IN = 1'b1; DWrite_IN = 1'b0; DAddr_IN = 32'h1001_0F04; DSize_IN = SIZE_WORD;
        n = 0;
        do begin
            @(negedge CLOCK);
            n++;
        end while (!MemReq_OUT && n < 20);
        check("mid_busy", {31'b0, MemReq_OUT}, 32'd1);
        @(negedge CLOCK);
        #2 RESET = 1'b0; DRead_IN = 1'b0;
        #1 checkAllZero("midreset");
        repeat (2) @(negedge CLOCK);
        RESET      = 1'b1;
        lastGrantM = GRANT_I;
        errSeen    = 1'b0;
        lastDData  = '0;
        iQ.delete();
        dQ.delete();
        @(posedge CLOCK); #2 monEn = 1'b1;

        // After reset: plain fetch, then contention grants D first,
        // then D alone followed by contention grants I first.
        issueI(32'h0040_0000);
        fork
            issueI(32'h0040_0004);
            issueD(32'h1001_0000, 1'b1, 1'b0, SIZE_WORD, 32'h0);
        join
        issueD(32'h1001_0004, 1'b0, 1'b1, SIZE_WORD, 32'h1234_5678);
        fork
            issueI(32'h0040_0008);
            issueD(32'h1001_0004, 1'b1, 1'b0, SIZE_WORD, 32'h0);
        join

        repeat (3) @(posedge CLOCK);
        check("queues_drained", 32'(iQ.size() + dQ.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
